multi_shift_sequencer: RTL and testbench

MULTI_SHIFT_SEQUENCER -- requirements
Module: multi_shift_sequencer

---
 rtl/shift_seq_pkg.sv | 19 +
 rtl/shift_step_4.sv | 31 +++
 rtl/multi_shift_sequencer.sv | 144 ++++++++++++++
 tb/tb_multi_shift_sequencer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the multi-step shift sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int MAX_STEP   = 2;
  localparam int DEF_DATA_W = 4;
  localparam int DEF_AMT_W  = 3;

endpackage

// File: rtl/shift_step_4.sv
// One combinational logical shift of a 4-bit word by 0..3 places, zero fill, with lost-bit flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
module shift_step_4
  import shift_seq_pkg::*;
(
  input  logic [3:0] i_data,
  input  logic [1:0] i_step,
  input  logic       i_dir,
  output logic [3:0] o_data,
  output logic       o_lost
);

  // Widen to 8 bits so the bits pushed off the end land in the spare half.
  logic [7:0] w_left;
  logic [7:0] w_right;

  // Left shift spills into [7:4]; right shift spills into [3:0].
  always_comb begin
    w_left  = {4'b0000, i_data} << i_step;
    w_right = {i_data, 4'b0000} >> i_step;
    if (i_dir == DIR_RIGHT) begin
      o_data = w_right[7:4];
      o_lost = |w_right[3:0];
    end else begin
      o_data = w_left[3:0];
      o_lost = |w_left[7:4];
    end
  end

endmodule

// File: rtl/multi_shift_sequencer.sv
// Applies a logical shift of 0..7 as a sequence of at most MAX_STEP-place steps, tracking lost ones.
// Latency: ceil(amt/2)+1 cycles from accept edge to out_valid.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, so no new request meanwhile.
module multi_shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int AMT_W    = DEF_AMT_W,
  parameter int MAX_STEP = shift_seq_pkg::MAX_STEP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic              in_dir,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_lost,
  output logic [AMT_W-1:0]  out_steps
);

  state_t            r_state;
  state_t            w_nxt;

  // Working copy of the operation; published outputs are kept separately so
  // they show the previous result until the new one is complete.
  logic [DATA_W-1:0] r_work;
  logic [AMT_W-1:0]  r_rem;
  logic              r_dir;
  logic              r_wlost;
  logic [AMT_W-1:0]  r_wsteps;

  logic [DATA_W-1:0] r_out_data;
  logic              r_out_lost;
  logic [AMT_W-1:0]  r_out_steps;

  logic [1:0]        w_step;
  logic [DATA_W-1:0] w_shd;
  logic              w_lost;

  // Per-cycle step is the remaining amount capped at MAX_STEP.
  always_comb begin
    w_step = r_rem[1:0];
    if (r_rem > AMT_W'(MAX_STEP)) begin
      w_step = 2'(MAX_STEP);
    end
  end

  shift_step_4 u_step (
    .i_data (r_work),
    .i_step (w_step),
    .i_dir  (r_dir),
    .o_data (w_shd),
    .o_lost (w_lost)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  // Next-state logic; SHIFT exits only when the remaining amount is used up.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_nxt = (in_amt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (r_rem == AMT_W'(w_step)) begin
          w_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_nxt = ST_IDLE;
        end
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  // Capture, per-step update and result publication.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_work      <= '0;
      r_rem       <= '0;
      r_dir       <= DIR_LEFT;
      r_wlost     <= 1'b0;
      r_wsteps    <= '0;
      r_out_data  <= '0;
      r_out_lost  <= 1'b0;
      r_out_steps <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_work   <= in_data;
            r_rem    <= in_amt;
            r_dir    <= in_dir;
            r_wlost  <= 1'b0;
            r_wsteps <= '0;
            if (in_amt == '0) begin
              r_out_data  <= in_data;
              r_out_lost  <= 1'b0;
              r_out_steps <= '0;
            end
          end
        end
        ST_SHIFT: begin
          r_work   <= w_shd;
          r_wlost  <= r_wlost | w_lost;
          r_wsteps <= r_wsteps + AMT_W'(1);
          r_rem    <= r_rem - AMT_W'(w_step);
          if (w_nxt == ST_DONE) begin
            r_out_data  <= w_shd;
            r_out_lost  <= r_wlost | w_lost;
            r_out_steps <= r_wsteps + AMT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake flags; in_ready is also gated by reset so it reads 0 while held.
  always_comb begin
    in_ready  = (r_state == ST_IDLE) && rst_n;
    out_valid = (r_state == ST_DONE);
    out_data  = r_out_data;
    out_lost  = r_out_lost;
    out_steps = r_out_steps;
  end

endmodule

// File: tb/tb_multi_shift_sequencer.sv
// Directed bench for multi_shift_sequencer with hand-computed expected results.
// Latency: checks ceil(amt/2)+1 cycles from accept to out_valid.
// Backpressure: exercises out_ready=0 hold in DONE and reset mid-operation.
module tb_multi_shift_sequencer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [2:0] in_amt;
  logic       in_dir;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_lost;
  logic [2:0] out_steps;

  int         n_checks;
  int         n_err;
  logic [3:0] prev_data;

  multi_shift_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_dir    (in_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_lost  (out_lost),
    .out_steps (out_steps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request, measure latency, check result, then consume it.
  task automatic run(input string tag, input logic [3:0] d, input logic [2:0] a, input logic dir,
                     input logic [3:0] ed, input logic el, input logic [2:0] es, input int elat);
    int   lat;
    logic hold_ok;
    check({tag, "_in_ready_idle"}, in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_dir   = dir;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = ~d;
    in_amt   = 3'd5;
    in_dir   = ~dir;
    lat      = 1;
    hold_ok  = 1'b1;
    while (!out_valid && lat < 20) begin
      if (out_data !== prev_data) hold_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_prev_held"}, hold_ok, 1);
    check({tag, "_latency"}, lat, elat);
    check({tag, "_data"}, out_data, ed);
    check({tag, "_lost"}, out_lost, el);
    check({tag, "_steps"}, out_steps, es);
    check({tag, "_in_ready_done"}, in_ready, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_after"}, out_valid, 0);
    check({tag, "_ready_after"}, in_ready, 1);
    prev_data = ed;
  endtask

  initial begin
    logic       seen_valid;
    logic [3:0] held;
    n_checks  = 0;
    n_err     = 0;
    prev_data = 4'h0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    in_amt    = 3'd0;
    in_dir    = 1'b0;
    out_ready = 1'b0;

    // Reset state.
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_lost", out_lost, 0);
    check("rst_out_steps", out_steps, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_in_ready", in_ready, 1);

    // Directed vectors.
    run("v_1011_l1", 4'b1011, 3'd1, 1'b0, 4'b0110, 1'b1, 3'd1, 2);
    run("v_1011_r3", 4'b1011, 3'd3, 1'b1, 4'b0001, 1'b1, 3'd2, 3);
    run("v_0101_a0", 4'b0101, 3'd0, 1'b0, 4'b0101, 1'b0, 3'd0, 1);
    run("v_1111_l7", 4'b1111, 3'd7, 1'b0, 4'b0000, 1'b1, 3'd4, 5);
    run("v_0001_r4", 4'b0001, 3'd4, 1'b1, 4'b0000, 1'b1, 3'd2, 3);
    run("v_1000_r2", 4'b1000, 3'd2, 1'b1, 4'b0010, 1'b0, 3'd1, 2);
    run("v_0000_l5", 4'b0000, 3'd5, 1'b0, 4'b0000, 1'b0, 3'd3, 4);
    run("v_0110_l2", 4'b0110, 3'd2, 1'b0, 4'b1000, 1'b1, 3'd1, 2);

    // Backpressure: hold result in DONE with a competing request present.
    in_valid = 1'b1;
    in_data  = 4'b1011;
    in_amt   = 3'd1;
    in_dir   = 1'b0;
    @(posedge clk); #1;
    in_data  = 4'b1111;
    in_amt   = 3'd0;
    @(posedge clk); #1;
    check("bp_valid", out_valid, 1);
    held = 4'b0110;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_data", out_data, held);
      check("bp_hold_lost", out_lost, 1);
      check("bp_hold_steps", out_steps, 1);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_ready", in_ready, 1);
    check("bp_release_valid", out_valid, 0);
    check("bp_no_recapture", out_data, held);
    prev_data = held;

    // Reset during the second SHIFT cycle of an amt=6 request.
    in_valid = 1'b1;
    in_data  = 4'b1111;
    in_amt   = 3'd6;
    in_dir   = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    check("mid_rst_in_ready_low", in_ready, 0);
    @(posedge clk); #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_lost", out_lost, 0);
    check("mid_rst_steps", out_steps, 0);
    check("mid_rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rel_in_ready", in_ready, 1);
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen_valid = 1'b1;
      @(posedge clk); #1;
    end
    check("mid_no_valid", seen_valid, 0);
    prev_data = 4'h0;

    // Sequencer still works after the aborted request.
    run("v_after_rst", 4'b1011, 3'd1, 1'b0, 4'b0110, 1'b1, 3'd1, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
